// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the MEM/WB
// writeback and a FIFO of buffered MDU results. The pipeline normally wins.
// The MDU is forced through when its FIFO is full or its head has starved.
// Optional feature macro: WBARB_PERF_EN adds stall_cnt_o, a saturating
// count of stalled cycles.
// Handshake: an MDU result is accepted on any clock edge where mdu_valid_i
// and mdu_ready_o are both high. mdu_ready_o depends only on the FIFO count.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          RegWrite_i,
    input  logic                          MemtoReg_i,
    input  logic [31:0]                   Data_i,
    input  logic [31:0]                   ALUout_i,
    input  logic [4:0]                    RDaddr_i,
    input  logic                          mdu_valid_i,
    output logic                          mdu_ready_o,
    input  logic [31:0]                   mdu_data_i,
    input  logic [4:0]                    mdu_rd_i,
    output logic                          stall_o,
    output logic                          rf_we_o,
    output logic [4:0]                    rf_addr_o,
    output logic [31:0]                   rf_data_o,
`ifdef WBARB_PERF_EN
    output logic [15:0]                   stall_cnt_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_NORM, S_FORCE} state_t;

    state_t          state_q, state_d;
    logic [FIFO_DEPTH-1:0] kill_q;
    logic [4:0]      rd_q   [FIFO_DEPTH];
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [3:0]      age_q;

    logic fifo_empty, fifo_full, pipe_req, mdu_req, head_drop, starved;
    logic grant_pipe, grant_mdu, push, pop;
    logic [31:0] pipe_data;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
    assign pipe_req     = RegWrite_i && (RDaddr_i != 5'd0);
    // A killed head or a head addressed to x0 never needs the port.
    assign mdu_req      = !fifo_empty && !kill_q[head_q] && (rd_q[head_q] != 5'd0);
    assign head_drop    = !fifo_empty && !mdu_req;
    assign starved      = (age_q >= 4'(STARVE_MAX));
    assign pipe_data    = MemtoReg_i ? Data_i : ALUout_i;
    assign push         = mdu_valid_i && !fifo_full;
    assign pop          = grant_mdu || head_drop;
    assign mdu_ready_o  = !fifo_full;
    assign fifo_count_o = count_q;
    assign stall_o      = pipe_req && grant_mdu;

    // Arbitration FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_NORM;
        else       state_q <= state_d;
    end

    // Grant selection; S_FORCE gives the pipeline one guaranteed cycle.
    always_comb begin
        state_d    = S_NORM;
        grant_pipe = 1'b0;
        grant_mdu  = 1'b0;
        case (state_q)
            S_NORM: begin
                if (pipe_req && mdu_req && (fifo_full || starved)) begin
                    grant_mdu = 1'b1;
                    state_d   = S_FORCE;
                end else if (pipe_req) begin
                    grant_pipe = 1'b1;
                end else if (mdu_req) begin
                    grant_mdu = 1'b1;
                end
            end
            S_FORCE: begin
                if (pipe_req)     grant_pipe = 1'b1;
                else if (mdu_req) grant_mdu  = 1'b1;
            end
            default: state_d = S_NORM;
        endcase
    end

    // FIFO control: pointers, occupancy and kill flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            if (grant_pipe) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (rd_q[i] == RDaddr_i) kill_q[i] <= 1'b1;
                end
            end
            if (push) begin
                kill_q[tail_q] <= grant_pipe && (mdu_rd_i == RDaddr_i);
                tail_q         <= tail_q + AW'(1);
            end
            if (pop) head_q <= head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless until written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_q[tail_q]   <= mdu_rd_i;
            data_q[tail_q] <= mdu_data_i;
        end
    end

    // Head age: counts cycles the live head is refused the port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                 age_q <= '0;
        else if (pop || fifo_empty)                age_q <= '0;
        else if (mdu_req && !grant_mdu && age_q != 4'hF) age_q <= age_q + 4'd1;
    end

    // Registered write port; address and data hold on idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
        end else if (grant_pipe) begin
            rf_we_o   <= 1'b1;
            rf_addr_o <= RDaddr_i;
            rf_data_o <= pipe_data;
        end else if (grant_mdu) begin
            rf_we_o   <= 1'b1;
            rf_addr_o <= rd_q[head_q];
            rf_data_o <= data_q[head_q];
        end else begin
            rf_we_o   <= 1'b0;
        end
    end

`ifdef WBARB_PERF_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              stall_cnt_o <= '0;
        else if (stall_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write, mem_to_reg;
  logic [31:0] data_in, alu_out, mdu_data;
  logic [4:0]  rd_addr, mdu_rd;
  logic        mdu_valid, mdu_ready, stall, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  fifo_count;
`ifdef WBARB_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
    .Data_i(data_in), .ALUout_i(alu_out), .RDaddr_i(rd_addr),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready),
    .mdu_data_i(mdu_data), .mdu_rd_i(mdu_rd),
    .stall_o(stall), .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
`ifdef WBARB_PERF_EN
    .stall_cnt_o(stall_cnt),
`endif
    .fifo_count_o(fifo_count)
  );

  // Behavioural model: a queue of pending results plus port registers.
  typedef struct {
    bit          kill;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_age;
  bit          m_forced;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_scnt;
  bit          last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_age = 0; m_forced = 0; m_we = 0; m_addr = 0; m_data = 0; m_scnt = 0;
    last_stall = 0;
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    reg_write = 0; mem_to_reg = 0; data_in = 0; alu_out = 0; rd_addr = 0;
    mdu_valid = 0; mdu_data = 0; mdu_rd = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive, compare against the model, then advance the model.
  task automatic drive_cycle(input logic rw, input logic mtr, input logic [31:0] d,
                             input logic [31:0] alu, input logic [4:0] rda,
                             input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit preq, head_ok, head_dead, force_now, gm, gp, exp_stall;
    int n;
    @(negedge clk);
    reg_write = rw; mem_to_reg = mtr; data_in = d; alu_out = alu; rd_addr = rda;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    n         = q.size();
    preq      = rw && (rda != 0);
    head_ok   = (n > 0) && !q[0].kill && (q[0].rd != 0);
    head_dead = (n > 0) && !head_ok;
    force_now = !m_forced && head_ok && preq && (n == 4 || m_age >= 8);
    gm        = force_now || (!preq && head_ok);
    gp        = preq && !gm;
    exp_stall = preq && gm;

    chk("rf_we", {31'b0, rf_we}, {31'b0, m_we});
    chk("rf_addr", {27'b0, rf_addr}, {27'b0, m_addr});
    chk("rf_data", rf_data, m_data);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, n < 4});
    chk("fifo_count", {29'b0, fifo_count}, 32'(n));
`ifdef WBARB_PERF_EN
    chk("stall_cnt", {16'b0, stall_cnt}, 32'(m_scnt));
    if (exp_stall && m_scnt < 16'hFFFF) m_scnt++;
`endif

    if (gp) begin
      m_we = 1; m_addr = rda; m_data = mtr ? d : alu;
      foreach (q[i]) if (q[i].rd == rda) q[i].kill = 1;
    end else if (gm) begin
      m_we = 1; m_addr = q[0].rd; m_data = q[0].data;
    end else begin
      m_we = 0;
    end
    if (gm || head_dead) q.pop_front();
    if (gm || head_dead || n == 0) m_age = 0;
    else if (head_ok && m_age < 15) m_age++;
    if (mv && n < 4) q.push_back('{kill: gp && (mrd == rda), rd: mrd, data: md});
    m_forced   = force_now;
    last_stall = exp_stall;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, stall_idx, w10;
    logic        rw, mtr;
    logic [31:0] d, alu;
    logic [4:0]  rda;

    reset_seq();
    #1;
    chk("reset rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset rf_addr", {27'b0, rf_addr}, 32'd0);
    chk("reset rf_data", rf_data, 32'd0);
    chk("reset count", {29'b0, fifo_count}, 32'd0);
    chk("reset ready", {31'b0, mdu_ready}, 32'd1);

    // Plain pipeline write.
    drive_cycle(1, 0, 32'h0, 32'h0000A5A5, 5, 0, 0, 0);
    @(posedge clk); #1;
    chk("t1 we", {31'b0, rf_we}, 32'd1);
    chk("t1 addr", {27'b0, rf_addr}, 32'd5);
    chk("t1 data", rf_data, 32'h0000A5A5);
    chk("t1 stall", {31'b0, stall}, 32'd0);

    // MDU result on an idle pipeline: two cycles to the port.
    drive_cycle(0, 0, 0, 0, 0, 1, 7, 32'h1234);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t2 we", {31'b0, rf_we}, 32'd1);
    chk("t2 addr", {27'b0, rf_addr}, 32'd7);
    chk("t2 data", rf_data, 32'h1234);
    chk("t2 count", {29'b0, fifo_count}, 32'd0);

    // Starvation under continuous pipeline writes.
    stalls = 0; stall_idx = -1; w10 = 0;
    for (int k = 0; k < 15; k++) begin
      drive_cycle(1, 0, 0, 32'h3333, 3, k == 0, 10, 32'hCAFE);
      if (stall) begin stalls++; stall_idx = k; end
      if (rf_we && rf_addr == 10) w10++;
    end
    chk("t3 stall cycle", 32'(stall_idx), 32'd9);
    chk("t3 stall count", 32'(stalls), 32'd1);
    chk("t3 mdu writes", 32'(w10), 32'd1);
    idle(3);

    // Full FIFO forces an immediate grant.
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1, 0, 0, 32'h4000 + k, 3, k < 4, 5'(11 + k), 32'hD00 + k);
      if (k == 4) begin
        chk("t4 ready full", {31'b0, mdu_ready}, 32'd0);
        chk("t4 forced stall", {31'b0, stall}, 32'd1);
        chk("t4 count full", {29'b0, fifo_count}, 32'd4);
      end
      if (k == 5) begin
        chk("t4 ready back", {31'b0, mdu_ready}, 32'd1);
        chk("t4 no b2b force", {31'b0, stall}, 32'd0);
      end
    end
    idle(8);

    // Pipeline write supersedes a buffered result to the same rd.
    drive_cycle(1, 0, 0, 32'h1, 3, 1, 9, 32'hDEAD);
    drive_cycle(1, 1, 32'hBEEF, 32'h2, 9, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5 addr", {27'b0, rf_addr}, 32'd9);
    chk("t5 data", rf_data, 32'hBEEF);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5 we idle", {31'b0, rf_we}, 32'd0);
    chk("t5 count", {29'b0, fifo_count}, 32'd0);
    idle(2);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 4; k++) drive_cycle(1, 0, 0, 32'h600 + k, 3, k < 3, 5'(20 + k), 32'hE0 + k);
    chk("t6 count before", {29'b0, fifo_count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6 async we", {31'b0, rf_we}, 32'd0);
    chk("t6 async count", {29'b0, fifo_count}, 32'd0);
    chk("t6 async stall", {31'b0, stall}, 32'd0);
    reset_seq();
    idle(4);
    chk("t6 no stale write", {31'b0, rf_we}, 32'd0);

    // Randomized traffic; a stalled pipeline request is held unchanged.
    rw = 0; mtr = 0; d = 0; alu = 0; rda = 0;
    for (int k = 0; k < 600; k++) begin
      if (!last_stall) begin
        rw  = ($urandom_range(0, 9) < 6);
        mtr = 1'($urandom_range(0, 1));
        d   = $urandom;
        alu = $urandom;
        rda = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      end
      drive_cycle(rw, mtr, d, alu, rda, ($urandom_range(0, 9) < 4),
                  5'($urandom_range(0, 5)), $urandom);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
